// File: rtl/mtimer_ctrl.sv
// mtimer_ctrl: memory-mapped 64-bit machine timer (mtime, mtimecmp, prescaler, MTIP).
// Bus slave with a 1-cycle ACK. Optional `MTIMER_SNAPSHOT_EN adds a tear-free HI shadow.
//
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   REQ, WE      bus request (held until ACK) and write enable
//   ADDR, WDATA  word address (ADDR[1:0] ignored) and write data
//   RDATA, ACK   read data and single-cycle completion pulse
//   MTIP         timer interrupt pending (registered mtime >= mtimecmp)
//   MTIME        live mtime value
module mtimer_ctrl #(
   parameter int unsigned PRESC_W = 8,
   parameter int unsigned RST_DIV = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ,
   input  logic        WE,
   input  logic [4:0]  ADDR,
   input  logic [31:0] WDATA,
   output logic [31:0] RDATA,
   output logic        ACK,
   output logic        MTIP,
   output logic [63:0] MTIME
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RESP = 1'b1;

   localparam logic [PRESC_W-1:0] DIV_RST = PRESC_W'(RST_DIV);

   localparam logic [2:0] R_MLO  = 3'd0;
   localparam logic [2:0] R_MHI  = 3'd1;
   localparam logic [2:0] R_CLO  = 3'd2;
   localparam logic [2:0] R_CHI  = 3'd3;
   localparam logic [2:0] R_CTRL = 3'd4;

   logic [0:0]         state_q, state_d;
   logic [63:0]        mtime_q, mtime_d;
   logic [63:0]        cmp_q, cmp_d;
   logic               en_q, en_d;
   logic [PRESC_W-1:0] div_q, div_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               ack_q, ack_d;
   logic               mtip_q, mtip_d;
   logic [31:0]        rdata_q, rdata_d;

   logic               access;
   logic               rd_acc;
   logic               wr_acc;
   logic               tick;
   logic [2:0]         reg_sel;
   logic [31:0]        ctrl_rd;
   logic [31:0]        hi_rd;
   logic [31:0]        rd_val;
   logic [1:0]         addr_unused;

   assign addr_unused = ADDR[1:0];

   // An access is taken on the edge where REQ is seen in IDLE.
   assign access  = (state_q == S_IDLE) && REQ;
   assign rd_acc  = access && !WE;
   assign wr_acc  = access && WE;
   assign reg_sel = ADDR[4:2];
   assign tick    = en_q && (presc_q == div_q);

   always_comb begin
      ctrl_rd = '0;
      ctrl_rd[8 +: PRESC_W] = div_q;
      ctrl_rd[0] = en_q;
   end

`ifdef MTIMER_SNAPSHOT_EN
   // LO read latches the upper half so a following HI read
   // returns a value consistent with the LO just read.
   logic [31:0] hi_shadow_q, hi_shadow_d;

   always_comb begin
      hi_shadow_d = hi_shadow_q;
      if (rd_acc && (reg_sel == R_MLO))
         hi_shadow_d = mtime_q[63:32];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         hi_shadow_q <= '0;
      else
         hi_shadow_q <= hi_shadow_d;
   end

   assign hi_rd = hi_shadow_q;
`else
   assign hi_rd = mtime_q[63:32];
`endif

   always_comb begin
      unique case (reg_sel)
         R_MLO:   rd_val = mtime_q[31:0];
         R_MHI:   rd_val = hi_rd;
         R_CLO:   rd_val = cmp_q[31:0];
         R_CHI:   rd_val = cmp_q[63:32];
         R_CTRL:  rd_val = ctrl_rd;
         default: rd_val = '0;
      endcase
   end

   always_comb begin
      state_d = access ? S_RESP : S_IDLE;
      ack_d   = access;
      rdata_d = rd_acc ? rd_val : '0;
      // Compare registered values: MTIP lags a change by one cycle.
      mtip_d  = (mtime_q >= cmp_q);

      mtime_d = mtime_q + {63'd0, tick};
      cmp_d   = cmp_q;
      en_d    = en_q;
      div_d   = div_q;

      if (!en_q || tick)
         presc_d = '0;
      else
         presc_d = presc_q + PRESC_W'(1);

      // A bus write to a mtime half wins over the tick and
      // leaves the other half untouched (no carry, no increment).
      if (wr_acc) begin
         unique case (reg_sel)
            R_MLO:  mtime_d = {mtime_q[63:32], WDATA};
            R_MHI:  mtime_d = {WDATA, mtime_q[31:0]};
            R_CLO:  cmp_d   = {cmp_q[63:32], WDATA};
            R_CHI:  cmp_d   = {WDATA, cmp_q[31:0]};
            R_CTRL: begin
               en_d    = WDATA[0];
               div_d   = WDATA[8 +: PRESC_W];
               presc_d = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         mtime_q <= '0;
         cmp_q   <= '1;
         en_q    <= 1'b0;
         div_q   <= DIV_RST;
         presc_q <= '0;
         ack_q   <= 1'b0;
         mtip_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         mtime_q <= mtime_d;
         cmp_q   <= cmp_d;
         en_q    <= en_d;
         div_q   <= div_d;
         presc_q <= presc_d;
         ack_q   <= ack_d;
         mtip_q  <= mtip_d;
         rdata_q <= rdata_d;
      end
   end

   assign RDATA = rdata_q;
   assign ACK   = ack_q;
   assign MTIP  = mtip_q;
   assign MTIME = mtime_q;

endmodule

// File: tb/tb_mtimer_ctrl.sv
// tb_mtimer_ctrl: directed and random bus traffic against a cycle-level
// behavioural model of the timer (tick arithmetic, register map, MTIP).
module tb_mtimer_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REQ = 1'b0;
   logic        WE = 1'b0;
   logic [4:0]  ADDR = '0;
   logic [31:0] WDATA = '0;
   logic [31:0] RDATA;
   logic        ACK;
   logic        MTIP;
   logic [63:0] MTIME;

   int errors = 0;
   int checks = 0;

   mtimer_ctrl dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE),
      .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA),
      .ACK(ACK), .MTIP(MTIP), .MTIME(MTIME)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   logic [63:0]     m_mtime, m_cmp;
   bit              m_en, m_ack, m_mtip;
   int              m_div;
   longint unsigned m_run;
   logic [31:0]     m_rdata, m_shadow;

   task automatic model_reset();
      m_mtime = 64'd0;
      m_cmp = {64{1'b1}};
      m_en = 0;
      m_div = 0;
      m_run = 0;
      m_ack = 0;
      m_mtip = 0;
      m_rdata = 32'd0;
      m_shadow = 32'd0;
   endtask

   // One clock edge: ticks occur when the cycles elapsed since the
   // last CTRL write (while enabled) reach div modulo (div+1).
   task automatic model_edge();
      bit acc, tk, ctrl_wr;
      int sel;
      logic [31:0] rv;
      logic [63:0] nm, nc;
      acc = REQ && !m_ack;
      tk = m_en && ((m_run % longint'(m_div + 1)) == longint'(m_div));
      sel = int'(ADDR[4:2]);
      case (sel)
         0: rv = m_mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
         1: rv = m_shadow;
`else
         1: rv = m_mtime[63:32];
`endif
         2: rv = m_cmp[31:0];
         3: rv = m_cmp[63:32];
         4: rv = (32'(m_div) << 8) | 32'(m_en);
         default: rv = 32'd0;
      endcase
      nm = m_mtime + 64'(tk);
      nc = m_cmp;
      ctrl_wr = 0;
      m_mtip = (m_mtime >= m_cmp);
      if (acc && WE) begin
         case (sel)
            0: nm = {m_mtime[63:32], WDATA};
            1: nm = {WDATA, m_mtime[31:0]};
            2: nc = {m_cmp[63:32], WDATA};
            3: nc = {WDATA, m_cmp[31:0]};
            4: ctrl_wr = 1;
            default: ;
         endcase
      end
      if (ctrl_wr || !m_en) m_run = 0;
      else m_run = m_run + 1;
      if (ctrl_wr) begin
         m_en = WDATA[0];
         m_div = int'(WDATA[15:8]);
      end
      if (acc && !WE) begin
         m_rdata = rv;
         if (sel == 0) m_shadow = m_mtime[63:32];
      end
      m_mtime = nm;
      m_cmp = nc;
      m_ack = acc;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      REQ = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   // One bus access with REQ dropped together with ACK. Returns what was
   // observed in the ACK cycle and the cycle after, plus model expectations.
   task automatic bus(input bit we, input logic [4:0] a,
                      input logic [31:0] d,
                      output bit ack1, output logic [31:0] rd,
                      output logic [63:0] mt, output bit ack2,
                      output logic [31:0] exp_rd,
                      output logic [63:0] exp_mt);
      REQ = 1'b1;
      WE = we;
      ADDR = a;
      WDATA = d;
      step();
      ack1 = ACK;
      rd = RDATA;
      mt = MTIME;
      exp_rd = m_rdata;
      exp_mt = m_mtime;
      REQ = 1'b0;
      WE = 1'b0;
      step();
      ack2 = ACK;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bit a1, a2;
      logic [31:0] rd, erd;
      logic [63:0] mt, emt;
      logic [31:0] exp_v [5];
      exp_v[0] = 32'h0;
      exp_v[1] = 32'h0;
      exp_v[2] = 32'hFFFF_FFFF;
      exp_v[3] = 32'hFFFF_FFFF;
      exp_v[4] = 32'h0;
      apply_reset();
      checks++;
      if (MTIP !== 1'b0 || ACK !== 1'b0 || MTIME !== 64'd0) begin
         errors++;
         $display("FAIL reset_out: mtip=%b ack=%b mtime=%h want 0,0,0",
                  MTIP, ACK, MTIME);
      end
      for (int i = 0; i < 5; i++) begin
         bus(0, 5'(i * 4), 32'd0, a1, rd, mt, a2, erd, emt);
         checks++;
         if (a1 !== 1'b1 || a2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack[%0d]: ack=%b,%b want 1,0", i, a1, a2);
         end
         checks++;
         if (rd !== exp_v[i]) begin
            errors++;
            $display("FAIL reset_rd[%0d]: got %h want %h", i, rd, exp_v[i]);
         end
      end
      checks++;
      if (MTIP !== 1'b0) begin
         errors++;
         $display("FAIL reset_mtip: got %b want 0", MTIP);
      end
   endtask

   task automatic test_prescale();
      bit a1, a2;
      logic [31:0] rd, erd;
      logic [63:0] mt, emt, frozen;
      bus(1, 5'h10, 32'h0000_0301, a1, rd, mt, a2, erd, emt);
      repeat (40) step();
      checks++;
      if (MTIME !== m_mtime) begin
         errors++;
         $display("FAIL presc_model: got %h want %h", MTIME, m_mtime);
      end
      checks++;
      if (MTIME < 64'd9 || MTIME > 64'd11) begin
         errors++;
         $display("FAIL presc_count: got %0d want 10+-1", MTIME);
      end
      bus(1, 5'h10, 32'h0000_0300, a1, rd, mt, a2, erd, emt);
      frozen = MTIME;
      repeat (10) step();
      checks++;
      if (MTIME !== frozen || MTIME !== m_mtime) begin
         errors++;
         $display("FAIL presc_frozen: got %h want %h", MTIME, frozen);
      end
      bus(0, 5'h10, 32'd0, a1, rd, mt, a2, erd, emt);
      checks++;
      if (rd !== 32'h0000_0300) begin
         errors++;
         $display("FAIL ctrl_read: got %h want 00000300", rd);
      end
   endtask

   task automatic test_mtip();
      bit a1, a2;
      logic [31:0] rd, erd;
      logic [63:0] mt, emt;
      int hit20, rise;
      hit20 = -1;
      rise = -1;
      bus(1, 5'h10, 32'h0, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h00, 32'h0, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h04, 32'h0, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h0C, 32'h0, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h08, 32'd20, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h10, 32'h1, a1, rd, mt, a2, erd, emt);
      for (int c = 0; c < 40; c++) begin
         step();
         checks++;
         if (MTIP !== m_mtip) begin
            errors++;
            $display("FAIL mtip_trace[%0d]: got %b want %b", c, MTIP, m_mtip);
         end
         if (hit20 < 0 && MTIME == 64'd20) hit20 = c;
         if (rise < 0 && MTIP === 1'b1) rise = c;
      end
      checks++;
      if (hit20 < 0 || rise != hit20 + 1) begin
         errors++;
         $display("FAIL mtip_rise: rise at %0d want %0d", rise, hit20 + 1);
      end
      bus(1, 5'h08, 32'hFFFF_FFFF, a1, rd, mt, a2, erd, emt);
      step();
      checks++;
      if (MTIP !== 1'b0 || MTIP !== m_mtip) begin
         errors++;
         $display("FAIL mtip_fall: got %b want 0", MTIP);
      end
   endtask

   task automatic test_carry();
      bit a1, a2;
      logic [31:0] rd, erd;
      logic [63:0] mt, emt;
      bus(1, 5'h10, 32'h0, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h00, 32'hFFFF_FFFF, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h04, 32'h0, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h10, 32'h1, a1, rd, mt, a2, erd, emt);
      checks++;
      if (MTIME !== 64'h0000_0001_0000_0000 || MTIME !== m_mtime) begin
         errors++;
         $display("FAIL lo_carry: got %h want 0000000100000000", MTIME);
      end
      bus(1, 5'h00, 32'd5, a1, rd, mt, a2, erd, emt);
      checks++;
      if (mt[31:0] !== 32'd5 || mt !== emt) begin
         errors++;
         $display("FAIL wr_wins_tick: got %h want %h", mt, emt);
      end
      bus(1, 5'h04, 32'hABCD_0000, a1, rd, mt, a2, erd, emt);
      checks++;
      if (mt[63:32] !== 32'hABCD_0000 || mt !== emt) begin
         errors++;
         $display("FAIL wr_hi_tick: got %h want %h", mt, emt);
      end
      bus(1, 5'h10, 32'h0, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h00, 32'hFFFF_FFFF, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h04, 32'hFFFF_FFFF, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h10, 32'h1, a1, rd, mt, a2, erd, emt);
      checks++;
      if (MTIME !== 64'd0 || MTIME !== m_mtime) begin
         errors++;
         $display("FAIL wrap64: got %h want 0", MTIME);
      end
   endtask

   task automatic test_snapshot();
      bit a1, a2;
      logic [31:0] rd_lo, rd_hi, erd, exp_hi;
      logic [63:0] mt, emt;
`ifdef MTIMER_SNAPSHOT_EN
      exp_hi = 32'd7;
`else
      exp_hi = 32'd8;
`endif
      bus(1, 5'h10, 32'h0, a1, rd_lo, mt, a2, erd, emt);
      bus(1, 5'h00, 32'hFFFF_FFFE, a1, rd_lo, mt, a2, erd, emt);
      bus(1, 5'h04, 32'd7, a1, rd_lo, mt, a2, erd, emt);
      bus(1, 5'h10, 32'h1, a1, rd_lo, mt, a2, erd, emt);
      bus(0, 5'h00, 32'h0, a1, rd_lo, mt, a2, erd, emt);
      checks++;
      if (rd_lo !== 32'hFFFF_FFFF || rd_lo !== erd) begin
         errors++;
         $display("FAIL snap_lo: got %h want ffffffff", rd_lo);
      end
      bus(0, 5'h04, 32'h0, a1, rd_hi, mt, a2, erd, emt);
      checks++;
      if (rd_hi !== exp_hi || rd_hi !== erd) begin
         errors++;
         $display("FAIL snap_hi: got %h want %h", rd_hi, exp_hi);
      end
   endtask

   task automatic test_back_to_back();
      int acks;
      acks = 0;
      REQ = 1'b1;
      WE = 1'b0;
      ADDR = 5'h08;
      for (int c = 0; c < 6; c++) begin
         step();
         checks++;
         if (ACK !== m_ack) begin
            errors++;
            $display("FAIL b2b_ack[%0d]: got %b want %b", c, ACK, m_ack);
         end
         if (ACK === 1'b1) begin
            acks++;
            checks++;
            if (RDATA !== m_rdata) begin
               errors++;
               $display("FAIL b2b_rd[%0d]: got %h want %h",
                        c, RDATA, m_rdata);
            end
         end
      end
      REQ = 1'b0;
      step();
      checks++;
      if (acks != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 3", acks);
      end
   endtask

   task automatic test_reset_mid();
      bit a1, a2;
      logic [31:0] rd, erd;
      logic [63:0] mt, emt;
      bus(1, 5'h10, 32'h0000_0201, a1, rd, mt, a2, erd, emt);
      bus(1, 5'h08, 32'h0, a1, rd, mt, a2, erd, emt);
      repeat (8) step();
      REQ = 1'b1;
      WE = 1'b0;
      ADDR = 5'h00;
      step();
      checks++;
      if (ACK !== 1'b1) begin
         errors++;
         $display("FAIL mid_ack_pre: got %b want 1", ACK);
      end
      REQ = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      checks++;
      if (ACK !== 1'b0 || RDATA !== 32'd0 || MTIME !== 64'd0
          || MTIP !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: ack=%b rd=%h mt=%h mtip=%b want 0",
                  ACK, RDATA, MTIME, MTIP);
      end
      apply_reset();
      bus(0, 5'h08, 32'h0, a1, rd, mt, a2, erd, emt);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL mid_cmp: got %h want ffffffff", rd);
      end
      bus(0, 5'h10, 32'h0, a1, rd, mt, a2, erd, emt);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL mid_ctrl: got %h want 0", rd);
      end
      bus(1, 5'h18, 32'hDEAD_BEEF, a1, rd, mt, a2, erd, emt);
      checks++;
      if (a1 !== 1'b1) begin
         errors++;
         $display("FAIL unmap_wr_ack: got %b want 1", a1);
      end
      bus(0, 5'h18, 32'h0, a1, rd, mt, a2, erd, emt);
      checks++;
      if (a1 !== 1'b1 || rd !== 32'd0) begin
         errors++;
         $display("FAIL unmap_rd: ack=%b rd=%h want 1,0", a1, rd);
      end
   endtask

   task automatic test_random();
      bit a1, a2, we;
      logic [31:0] rd, erd, d;
      logic [63:0] mt, emt;
      logic [4:0] a;
      int gap, sel;
      logic [4:0] addrs [6];
      addrs[0] = 5'h00;
      addrs[1] = 5'h04;
      addrs[2] = 5'h08;
      addrs[3] = 5'h0C;
      addrs[4] = 5'h10;
      addrs[5] = 5'h18;
      for (int n = 0; n < 300; n++) begin
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            step();
            checks++;
            if (MTIME !== m_mtime || MTIP !== m_mtip) begin
               errors++;
               $display("FAIL rnd_idle[%0d]: mt=%h/%b want %h/%b",
                        n, MTIME, MTIP, m_mtime, m_mtip);
            end
         end
         sel = int'($urandom_range(0, 5));
         a = addrs[sel];
         we = 1'($urandom_range(0, 1));
         if (sel == 4)
            d = {16'd0, 8'($urandom_range(0, 3)), 7'd0,
                 1'($urandom_range(0, 3) != 0)};
         else if (sel == 1 || sel == 3)
            d = 32'($urandom_range(0, 1));
         else
            d = 32'($urandom_range(0, 300));
         bus(we, a, d, a1, rd, mt, a2, erd, emt);
         checks++;
         if (a1 !== 1'b1 || a2 !== 1'b0) begin
            errors++;
            $display("FAIL rnd_ack[%0d]: ack=%b,%b want 1,0", n, a1, a2);
         end
         if (!we) begin
            checks++;
            if (rd !== erd) begin
               errors++;
               $display("FAIL rnd_rd[%0d] a=%h: got %h want %h",
                        n, a, rd, erd);
            end
         end
         checks++;
         if (mt !== emt || MTIME !== m_mtime || MTIP !== m_mtip) begin
            errors++;
            $display("FAIL rnd_state[%0d]: mt=%h mtip=%b want %h %b",
                     n, MTIME, MTIP, m_mtime, m_mtip);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_prescale();
      test_mtip();
      test_carry();
      test_snapshot();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
